// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : HI/LO multiply / multiply-accumulate / restoring-divide unit
// Revision    : 1.0
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2,
    parameter int DIV_EN  = 1
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;

    localparam logic [1:0] MAC_NONE = 2'd0;
    localparam logic [1:0] MAC_ADD  = 2'd1;
    localparam logic [1:0] MAC_SUB  = 2'd2;

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [1:0]         mac_q, mac_d;
    logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

    // Multiplier: operands sign-extended to 2*WIDTH so the low half of the
    // product is the exact signed or unsigned result.
    logic                 w_mul_sgn;
    logic [2*WIDTH-1:0]   w_mul_a, w_mul_b, w_prod, w_hilo, w_mul_res;
    logic [2*WIDTH-1:0]   prod_q [MUL_LAT];

    assign w_mul_sgn = (Op != OP_MULTU);
    assign w_mul_a   = {{WIDTH{w_mul_sgn & A[WIDTH-1]}}, A};
    assign w_mul_b   = {{WIDTH{w_mul_sgn & B[WIDTH-1]}}, B};
    assign w_prod    = w_mul_a * w_mul_b;
    assign w_hilo    = {hi_q, lo_q};

    // Free-running datapath pipeline; only the FSM decides when it is consumed.
    always_ff @(posedge Clock) begin
        prod_q[0] <= w_prod;
        for (int k = 1; k < MUL_LAT; k++) begin
            prod_q[k] <= prod_q[k-1];
        end
    end

    always_comb begin
        case (mac_q)
            MAC_ADD: w_mul_res = w_hilo + prod_q[MUL_LAT-1];
            MAC_SUB: w_mul_res = w_hilo - prod_q[MUL_LAT-1];
            default: w_mul_res = prod_q[MUL_LAT-1];
        endcase
    end

    // Divider works on magnitudes; signs are restored in the FIX cycle.
    logic               w_div_sgn, w_a_neg, w_b_neg, w_div_ge;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_div_sub, w_quo_fix, w_rem_fix;
    logic [WIDTH:0]     w_div_r;

    assign w_div_sgn = (Op == OP_DIV);
    assign w_a_neg   = w_div_sgn & A[WIDTH-1];
    assign w_b_neg   = w_div_sgn & B[WIDTH-1];
    assign w_a_mag   = w_a_neg ? (~A + 1'b1) : A;
    assign w_b_mag   = w_b_neg ? (~B + 1'b1) : B;
    assign w_div_r   = {rem_q, quo_q[WIDTH-1]};
    assign w_div_ge  = (w_div_r >= {1'b0, dvs_q});
    assign w_div_sub = w_div_r[WIDTH-1:0] - dvs_q;
    assign w_quo_fix = dz_q ? '1 : (qneg_q ? (~quo_q + 1'b1) : quo_q);
    assign w_rem_fix = rneg_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        mac_d   = mac_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (Start && !Flush) begin
                    case (Op)
                        OP_MULT, OP_MULTU: begin
                            state_d = S_MUL;
                            cnt_d   = '0;
                            mac_d   = MAC_NONE;
                        end
                        OP_MADD: begin
                            state_d = S_MUL;
                            cnt_d   = '0;
                            mac_d   = MAC_ADD;
                        end
                        OP_MSUB: begin
                            state_d = S_MUL;
                            cnt_d   = '0;
                            mac_d   = MAC_SUB;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (DIV_EN != 0) begin
                                state_d = S_DIV;
                                cnt_d   = '0;
                                quo_d   = w_a_mag;
                                rem_d   = '0;
                                dvs_d   = w_b_mag;
                                qneg_d  = w_a_neg ^ w_b_neg;
                                rneg_d  = w_a_neg;
                                dz_d    = (B == '0);
                            end else begin
                                done_d  = 1'b1;
                            end
                        end
                        OP_MTHI: begin
                            hi_d   = A;
                            done_d = 1'b1;
                        end
                        default: begin
                            lo_d   = A;
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    {hi_d, lo_d} = w_mul_res;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                if (Flush) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], w_div_ge};
                    rem_d = w_div_ge ? w_div_sub : w_div_r[WIDTH-1:0];
                    if (cnt_q == DIV_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!Flush) begin
                    hi_d   = w_rem_fix;
                    lo_d   = w_quo_fix;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mac_q   <= MAC_NONE;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mac_q   <= mac_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
`default_nettype wire
